// File: rtl/nsa_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

endpackage

// File: rtl/four_bit_adder.sv
// Purpose: 4-bit ripple adder slice with carry in/out.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Purpose: adds two W-bit operands plus carry-in one nibble per cycle through a single 4-bit adder.
// Latency: out_valid rises NIBBLES+1 edges after the accepting edge (accept edge counted as the first).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE. NSA_OVERFLOW_EN adds out_ovf.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  in_b,
    input  logic                         in_cin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  out_sum,
    output logic                         out_cout,
    output logic                         busy
`ifdef NSA_OVERFLOW_EN
    ,
    output logic                         out_ovf
`endif
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    nsa_state_t          state_q, state_d;
    logic [W-1:0]        a_q, b_q, sum_q;
    logic                carry_q;
    logic [IDX_W-1:0]    idx_q;
    logic [NIBBLE_W-1:0] a_nib, b_nib, nib_sum;
    logic                nib_cout;

    // Slice mux: the current nibble of each captured operand feeds the adder.
    assign a_nib = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

    four_bit_adder u_adder (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs decoded purely from the current state.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Last slice is written this cycle, so DONE follows directly.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then ripple one nibble per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        carry_q <= in_cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry_q <= nib_cout;
                    // Index parks on the last slice instead of wrapping.
                    if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NSA_OVERFLOW_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB (recovered from the top slice) XOR carry out.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && idx_q == LAST_IDX) begin
            ovf_q <= (a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1] ^ nib_sum[NIBBLE_W-1]) ^ nib_cout;
        end
    end

    assign out_ovf = ovf_q;
`endif

    assign out_sum  = sum_q;
    assign out_cout = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Purpose: scoreboard bench for nibble_serial_adder (NIBBLES=4), covers NSA_OVERFLOW_EN when defined.
// Latency: checks out_valid NIBBLES+1 edges after accept and NIBBLES+2 cycle back-to-back spacing.
// Backpressure: exercises a 10-cycle out_ready stall and a reset abort mid-operation.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;
`ifdef NSA_OVERFLOW_EN
    logic         out_ovf;
`endif

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_acc = -1;
    bit   b2b = 1'b0;
    bit   prev_v = 1'b0;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
`ifdef NSA_OVERFLOW_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int acc);
        exp_t e;
        logic [W:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        e.acc  = acc;
        return e;
    endfunction

    // Monitor: compare held results against the scoreboard head, pop on handshake, record accepts.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            sb.delete();
            prev_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    if (!prev_v) check("latency", 64'(cyc - sb[0].acc + 1), 64'(NIBBLES + 1));
                    check("sum", 64'(out_sum), 64'(sb[0].sum));
                    check("cout", 64'(out_cout), 64'(sb[0].cout));
`ifdef NSA_OVERFLOW_EN
                    check("ovf", 64'(out_ovf), 64'(sb[0].ovf));
`endif
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_v = out_valid;
            if (in_valid && in_ready) begin
                sb.push_back(model(in_a, in_b, in_cin, cyc + 1));
                if (b2b && last_acc >= 0) check("spacing", 64'(cyc + 1 - last_acc), 64'(NIBBLES + 2));
                last_acc = cyc + 1;
            end
        end
    end

    // Hold in_valid until an accept edge passes, then drop it and scramble operands.
    task automatic wait_accept();
        bit got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = 1'($urandom);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(posedge clk); #1;
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        wait_accept();
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
        check({tag, "_sum"},       64'(out_sum),   64'd0);
        check({tag, "_cout"},      64'(out_cout),  64'd0);
`ifdef NSA_OVERFLOW_EN
        check({tag, "_ovf"},       64'(out_ovf),   64'd0);
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");

        // Directed vectors.
        send(16'h1234, 16'h0001, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h7FFF, 16'h0000, 1'b1);
        send(16'h8000, 16'h8000, 1'b0);
        drain();

        // Stall in DONE for 10 cycles with a new operand offered.
        out_ready = 1'b0;
        send(16'hBEEF, 16'h1111, 1'b1);
        begin
            bit seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            if (!seen) check("stall_valid_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        in_a = 16'h0F00; in_b = 16'h00F0; in_cin = 1'b1; in_valid = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        drain();

        // Reset during the second RUN cycle discards the operation.
        send(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("abort");
        repeat (8) @(negedge clk);
        check("abort_no_valid", 64'(sb.size()), 64'd0);
        send(16'h0F0F, 16'hF0F0, 1'b1);
        drain();

        // Back-to-back with in_valid and out_ready held high.
        b2b = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 100; i++) begin
            bit got = 1'b0;
            @(posedge clk); #1;
            in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
            in_valid = 1'b1;
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
            end
            if (!got) check("b2b_accept_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        b2b = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
